// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package inst_fetch_pkg;

    localparam int INST_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Prefetch queue: circular buffer of any depth with flush; head is zero when empty.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Flush overrides both push and pop; a full queue accepts a push only alongside a pop.
    assign do_pop_s  = pop && !flush && (count_q != '0);
    assign do_push_s = push && !flush && ((count_q != CW'(DEPTH)) || do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_pop_s) begin
                rd_q <= ptr_inc(rd_q);
            end
            if (do_push_s) begin
                wr_q <= ptr_inc(wr_q);
            end
            count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= din;
        end
    end

    assign dout  = (count_q != '0) ? mem_q[rd_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited request issue into a prefetch queue, with
// redirect flush and in-order discard of responses to abandoned reads.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_e             state_q;
    logic [ADDR_W-1:0]        pc_q;
    logic [CW-1:0]            out_q;
    logic [CW-1:0]            q_count_s;
    logic [CW:0]              inflight_s;
    logic [CW-1:0]            out_after_rv_s;
    logic                     grant_s;
    logic                     rv_ok_s;
    logic                     push_s;
    logic                     pop_s;
    logic [ADDR_W-1:0]        resp_addr_s;
    logic [INST_W+ADDR_W-1:0] head_s;

    assign inflight_s     = {1'b0, q_count_s} + {1'b0, out_q};
    assign mem_req        = rst_n && (state_q == ST_FETCH) && !redirect
                            && (inflight_s < (CW+1)'(QDEPTH));
    assign mem_addr       = pc_q;
    assign grant_s        = mem_req && mem_gnt;
    assign rv_ok_s        = mem_rvalid && (out_q != '0);
    assign out_after_rv_s = out_q - CW'(rv_ok_s);

    // In FETCH the outstanding reads are the consecutive addresses just below PC.
    assign resp_addr_s = pc_q - ADDR_W'(out_q);
    assign push_s      = rv_ok_s && (state_q == ST_FETCH) && !redirect;
    assign pop_s       = inst_valid && inst_ready;

    inst_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (INST_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect),
        .din   ({mem_rdata, resp_addr_s}),
        .dout  (head_s),
        .count (q_count_s)
    );

    assign inst_valid = (q_count_s != '0);
    assign inst       = head_s[INST_W+ADDR_W-1:ADDR_W];
    assign inst_pc    = head_s[ADDR_W-1:0];

    // Fetch FSM; in DISCARD out_q is the number of responses still to be dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (redirect) begin
                        pc_q    <= redirect_pc;
                        out_q   <= out_after_rv_s;
                        state_q <= (out_after_rv_s != '0) ? ST_DISCARD : ST_FETCH;
                    end else begin
                        if (grant_s) begin
                            pc_q <= pc_inc(pc_q);
                        end
                        out_q <= out_after_rv_s + CW'(grant_s);
                    end
                end
                ST_DISCARD: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end
                    out_q <= out_after_rv_s;
                    if (out_after_rv_s == '0) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                    out_q   <= '0;
                end
            endcase
        end
    end

endmodule
